// File: rtl/key_cond_pkg.sv
// Shared constants and helpers for the key conditioner.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
package key_cond_pkg;

   localparam int unsigned NUM_KEYS            = 4;
   localparam logic        KEY_PRESSED         = 1'b0;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

   typedef logic [NUM_KEYS-1:0] key_vec_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce counter, edge pulses and,
// when KEY_AUTOREPEAT_EN is defined, an auto-repeat timer.
module key_debounce_ch
   import key_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int unsigned     DB_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      r_sync;
   logic            r_stable;
   logic [DB_W-1:0] r_db_cnt;
   logic            r_press;
   logic            r_release;

   logic w_key;
   logic w_differ;
   logic w_accept;
   logic w_press_acc;
   logic w_release_acc;
   logic w_rep_due;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_key_n};
      end
   end

   assign w_key         = r_sync[1];
   assign w_differ      = (w_key != r_stable);
   assign w_accept      = w_differ && (r_db_cnt == DB_LAST);
   assign w_press_acc   = w_accept && (w_key == KEY_PRESSED);
   assign w_release_acc = w_accept && (w_key != KEY_PRESSED);

   // Counter only runs while the input disagrees; any return to the stable value restarts it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stable <= ~KEY_PRESSED;
         r_db_cnt <= '0;
      end else if (!w_differ) begin
         r_db_cnt <= '0;
      end else if (w_accept) begin
         r_stable <= w_key;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + DB_W'(1);
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned      REP_W     = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] r_rep_cnt;
   logic             r_rep_first;
   logic             w_held;

   // Held excludes the release-accept edge so no repeat lands in the release cycle.
   assign w_held    = (r_stable == KEY_PRESSED) && !w_accept;
   assign w_rep_due = w_held && (r_rep_cnt == (r_rep_first ? REP_FIRST : REP_NEXT));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
      end else if (w_press_acc || !w_held) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
      end else if (w_rep_due) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b0;
      end else begin
         r_rep_cnt <= r_rep_cnt + REP_W'(1);
      end
   end
`else
   logic w_unused_rep;

   assign w_rep_due    = 1'b0;
   assign w_unused_rep = (REPEAT_DELAY == 0) ^ (REPEAT_PERIOD == 0);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= w_press_acc || w_rep_due;
         r_release <= w_release_acc;
      end
   end

   assign o_level   = (r_stable == KEY_PRESSED);
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/key_conditioner.sv
// Debounced, edge-detected push-button inputs for LED/FSM consumers.
// Define KEY_AUTOREPEAT_EN to add auto-repeat press pulses while a key is held.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .i_clk     (clk),
         .i_rst_n   (reset_n),
         .i_key_n   (key_n[g]),
         .o_level   (key_level[g]),
         .o_press   (key_press[g]),
         .o_release (key_release[g])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a window-based reference model queues
// expected pulse events; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_key_conditioner;

   localparam int unsigned DB   = 8;
   localparam int unsigned RD   = 20;
   localparam int unsigned RP   = 6;
   localparam int unsigned HIST = DB + 2;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] key_n   = 4'hF;
   logic [3:0] key_level;
   logic [3:0] key_press;
   logic [3:0] key_release;

   key_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_n       (key_n),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  press;
      logic [3:0]  rel;
   } evt_t;

   evt_t        exp_q[$];
   logic [3:0]  hist[$];
   logic [3:0]  m_stable;
   logic [3:0]  m_level;
   int unsigned m_cyc;
   int unsigned m_acc[4];
   int unsigned press_cnt[4];
   int unsigned rel_cnt[4];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, m_cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < HIST; i++) hist.push_back(4'hF);
      m_stable = 4'hF;
      m_level  = 4'h0;
      m_cyc    = 0;
      exp_q.delete();
   endtask

   // A key flips once the raw level seen two stages earlier has disagreed
   // with the stable state for DB consecutive samples.
   task automatic model_step();
      logic [3:0]  p;
      logic [3:0]  r;
      bit          all_diff;
      int unsigned d;
      evt_t        e;
      p = 4'h0;
      r = 4'h0;
      m_cyc++;
      hist.push_back(key_n);
      void'(hist.pop_front());
      for (int c = 0; c < 4; c++) begin
         all_diff = 1'b1;
         for (int j = 0; j < DB; j++) begin
            if (hist[j][c] == m_stable[c]) all_diff = 1'b0;
         end
         if (all_diff) begin
            m_stable[c] = ~m_stable[c];
            if (m_stable[c] == 1'b0) begin
               p[c]     = 1'b1;
               m_acc[c] = m_cyc;
            end else begin
               r[c] = 1'b1;
            end
         end else if (m_stable[c] == 1'b0) begin
            d = m_cyc - m_acc[c];
`ifdef KEY_AUTOREPEAT_EN
            if (d == RD || (d > RD && (d - RD) % RP == 0)) p[c] = 1'b1;
`endif
         end
      end
      m_level = ~m_stable;
      if ((p | r) != 4'h0) begin
         e.cyc   = m_cyc;
         e.press = p;
         e.rel   = r;
         exp_q.push_back(e);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_step();
   end

   always @(negedge clk) begin
      evt_t e;
      if (!reset_n) begin
         check("reset_outputs", 32'({key_level, key_press, key_release}), 32'h0);
      end else begin
         check("level", 32'(key_level), 32'(m_level));
         check("press_release_exclusive", 32'(key_press & key_release), 32'h0);
         for (int c = 0; c < 4; c++) begin
            press_cnt[c] += 32'(key_press[c]);
            rel_cnt[c]   += 32'(key_release[c]);
         end
         if ((key_press | key_release) != 4'h0 || (exp_q.size() > 0 && exp_q[0].cyc <= m_cyc)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pulse at cycle %0d: press %b release %b, expected none",
                        m_cyc, key_press, key_release);
            end else begin
               e = exp_q.pop_front();
               check("event_cycle", m_cyc, e.cyc);
               check("event_press", 32'(key_press), 32'(e.press));
               check("event_release", 32'(key_release), 32'(e.rel));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int unsigned base;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         press_cnt[c] = 0;
         rel_cnt[c]   = 0;
         m_acc[c]     = 0;
      end
      key_n   = 4'hF;
      reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(5);

      // Clean press on key 1
      base = press_cnt[1];
      key_n[1] = 1'b0;
      tick(30);
      check("clean_press_count", press_cnt[1] - base, 1);
      key_n[1] = 1'b1;
      tick(20);

      // Bounce on key 2: 5 low, 2 high, 20 low
      base = press_cnt[2];
      key_n[2] = 1'b0;
      tick(5);
      key_n[2] = 1'b1;
      tick(2);
      key_n[2] = 1'b0;
      tick(20);
      check("bounce_press_count", press_cnt[2] - base, 1);
      key_n[2] = 1'b1;
      tick(20);

      // Release on key 0 after 40 cycles held
      key_n[0] = 1'b0;
      tick(40);
      base = rel_cnt[0];
      key_n[0] = 1'b1;
      tick(20);
      check("release_count", rel_cnt[0] - base, 1);

      // All keys together
      key_n = 4'h0;
      tick(20);
      key_n = 4'hF;
      tick(20);

      // Reset while key 0 is mid-debounce (count 5)
      key_n[0] = 1'b0;
      tick(7);
      reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      base = press_cnt[0];
      tick(15);
      check("press_after_reset_count", press_cnt[0] - base, 1);
      key_n[0] = 1'b1;
      tick(15);

      // Hold key 3 for 50 cycles past acceptance
      base = press_cnt[3];
      key_n[3] = 1'b0;
      tick(61);
`ifdef KEY_AUTOREPEAT_EN
      check("repeat_press_count", press_cnt[3] - base, 7);
`else
      check("repeat_press_count", press_cnt[3] - base, 1);
`endif
      key_n[3] = 1'b1;
      tick(20);

      // Random keys with mixed hold lengths and occasional resets
      for (int i = 0; i < 900; i++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 11) == 0) key_n[c] = ~key_n[c];
         end
         if ($urandom_range(0, 249) == 0) begin
            reset_n = 1'b0;
            tick(2);
            reset_n = 1'b1;
         end
         tick(1);
      end

      key_n = 4'hF;
      tick(40);
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of clk cycles a synchronized key must hold a new value before it is accepted (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the number of cycles from accepted press to first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 5000000, giving the number of cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock for all logic; this is the 50 MHz board clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port key_n, input, 4 bits, raw asynchronous push-button levels, where 0 means pressed.
REQ-007 The block SHALL have port key_level, output, 4 bits, debounced active-high held state.
REQ-008 The block SHALL have port key_press, output, 4 bits, one-cycle pulse per accepted press (plus repeats when enabled).
REQ-009 The block SHALL have port key_release, output, 4 bits, one-cycle pulse per accepted release.

Function
REQ-010 The block SHALL handle each of the 4 channels independently and identically, with no cross-channel interaction.
REQ-011 The block SHALL pass each key_n bit through a 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL hold a stable state and a debounce counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-013 When the synchronized input equals the stable state, the counter SHALL be cleared to 0.
REQ-014 When the synchronized input differs from the stable state, the counter SHALL increment each cycle; on the cycle it reaches DEBOUNCE_CYCLES-1, the stable state SHALL take the input value and the counter SHALL clear.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL clear the counter on return and SHALL produce no output change.
REQ-016 Latency from a clean raw edge to the key_level change SHALL be exactly 2+DEBOUNCE_CYCLES clk edges.
REQ-017 key_level SHALL equal the inverse of the stable state.
REQ-018 key_press SHALL be high for exactly the one cycle after key_level goes 0->1; key_release SHALL be high for exactly the one cycle after key_level goes 1->0.
REQ-019 key_press and key_release SHALL never be high simultaneously on the same channel.
REQ-020 Simultaneous presses on several channels SHALL produce pulses on all of them in the same cycle.

Reset
REQ-021 While reset_n=0, synchronizer flops and stable states SHALL be 1 (released), counters 0, key_level 4'b0000, key_press 4'b0000, key_release 4'b0000.
REQ-022 A key held during reset release SHALL be reported as a fresh press after 2+DEBOUNCE_CYCLES cycles, with a single key_press pulse.
REQ-023 Reset asserted mid-count or mid-repeat SHALL abort immediately with no pulse emitted.

Configuration
REQ-024 With macro KEY_AUTOREPEAT_EN defined, a per-channel repeat counter SHALL start at accepted press.
REQ-025 With KEY_AUTOREPEAT_EN defined, while key_level stays 1, extra key_press pulses SHALL occur REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
REQ-026 With KEY_AUTOREPEAT_EN defined, release SHALL clear the repeat counter, and no repeat pulse SHALL occur in or after the release cycle.
REQ-027 Without KEY_AUTOREPEAT_EN, the repeat counter SHALL not exist, REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored, and exactly one key_press SHALL occur per accepted press.

Structure
REQ-028 Shared package key_cond_pkg SHALL hold NUM_KEYS=4, the key active-level constant KEY_PRESSED=1'b0, and the default timing constants.
REQ-029 Per-channel logic SHALL be sub-module key_debounce_ch (synchronizer, debounce counter, edge detect, optional repeat), instantiated NUM_KEYS times by key_conditioner.
REQ-030 Outputs SHALL drive LED/FSM consumers directly, replacing raw ~KEY usage.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6)
REQ-031 Clean press: key_n[1] 1->0 held 30 cycles -> key_level[1]=1 exactly 10 edges later, key_press[1] pulses once, key_release[1] quiet.
REQ-032 Bounce: key_n[2] low for 5 cycles, high 2, low 20 -> exactly one key_press[2], 10 edges after the last falling edge.
REQ-033 Release: key_n[0] released after 40 cycles held -> key_release[0] pulse 10 edges later, key_level[0]=0.
REQ-034 Simultaneous: key_n 4'b1111->4'b0000 -> key_press=4'b1111 in a single cycle.
REQ-035 Reset mid-debounce: reset_n low at count 5 with key_n held low -> all outputs 0; after release, press is reported 10 edges after reset_n rises.
REQ-036 Auto-repeat (macro defined): key_n[3] held 50 cycles after acceptance -> key_press[3] at +0, +20, +26, +32, +38, +44, +50 cycles; with no macro, a single pulse at +0.
